imem_fetch_responder: RTL
=========================

Name: imem_fetch_responder

Overview:
- Instruction-memory side of the fetch interface: accepts PC fetch requests from the fetch unit and returns the 32-bit instruction word after a fixed, parameterised latency.
- Holds a 2^DEPTH_LOG2-word program store mapped at BASE_ADDR, loadable through a side port by the bench or boot logic.
- Fully pipelined (one request per cycle) with out-of-range and misaligned-address error flagging.

Parameters:
- BASE_ADDR, 32'h00003000, byte address of word 0.
- DEPTH_LOG2, 10, log2 of the word count (1024 words = 4 KiB window).
- LATENCY, 1, cycles from request acceptance to response; legal range 1..4.

Ports:
- Clk  in  1  clock
- Reset  in  1  synchronous, active-high reset
- req_valid  in  1  fetch request present
- req_addr  in  32  byte PC to fetch
- req_ready  out  1  request accepted this cycle when high with req_valid
- rsp_valid  out  1  one-cycle pulse per accepted request
- rsp_instr  out  32  instruction word; 32'h00000000 on error
- rsp_addr  out  32  echo of req_addr for this response
- rsp_err  out  1  address misaligned or outside the window
- ld_en  in  1  program-load write strobe
- ld_addr  in  32  byte address of the load word
- ld_data  in  32  load word
- ld_err  out  1  registered pulse: last load was dropped (bad address)

Behaviour:
- Clock and reset: Reset is synchronous and active-high; Clk is the clock.
- Reset values: rsp_valid=0, rsp_instr=0, rsp_addr=0, rsp_err=0, ld_err=0. All pipeline valid bits clear.
- The memory array is NOT reset; its contents survive Reset.
- req_ready = !Reset && !ld_en. A load has priority; a request in a load cycle is stalled and must be held by the requester.
- Accept: req_valid && req_ready. On accept, the address is decoded:
  - err = (req_addr[1:0] != 0) || (req_addr < BASE_ADDR) || (req_addr >= BASE_ADDR + 4*2^DEPTH_LOG2).
  - index = (req_addr - BASE_ADDR)[DEPTH_LOG2+1:2].
- Pipeline: a LATENCY-deep shift of {valid, addr, err, data}.
  - Data is read asynchronously from the array at accept and registered into stage 1.
  - Stages 2..LATENCY forward unchanged.
  - The response appears exactly LATENCY cycles after the accept edge: with LATENCY=1, rsp_* is valid in the cycle following acceptance.
  - Back-to-back accepts give back-to-back responses, in order, with no bubbles.
- Error response: rsp_valid=1, rsp_err=1, rsp_instr=0, rsp_addr=request address. The array is not accessed.
- When no response is due, rsp_valid=0 and rsp_instr, rsp_addr and rsp_err hold their last values.
- Load: on ld_en, if ld_addr is aligned and in-window, the word is written at the clock edge and ld_err=0 next cycle. Otherwise the write is dropped and ld_err=1 for one cycle.
- Read-after-load: a request accepted in the cycle after a load to the same word returns the new data.
- In-flight reads are not affected by loads issued after acceptance, because the data was captured at accept.
- Reset during activity:
  - All in-flight responses are discarded; no rsp_valid is produced for them.
  - A load in the same cycle as Reset is still written, since the array is not reset; ld_err is forced to 0.
- Address arithmetic: BASE_ADDR + window size is computed in 33 bits so that a window at the top of the address space does not wrap.

Decomposition:
- Shared header constants:
  - IM_BASE (32'h00003000)
  - IM_DEPTH_LOG2 (10)
  - IM_NOP (32'h00000000)
  - IM_MAX_LATENCY (4)
- Sub-module: im_ram. A 2^DEPTH_LOG2 x 32 array with a synchronous write port (we, waddr, wdata) and a combinational read port (raddr, rdata); no reset.
- imem_fetch_responder contains the decode, handshake, error logic and latency pipeline.

Test Plan:
- Load 0x20080005 at 0x3000 and 0x20090007 at 0x3004, LATENCY=1. Request 0x3000 then 0x3004 on consecutive cycles -> rsp_valid on the next two cycles with 0x20080005 then 0x20090007, rsp_err=0, rsp_addr echoed.
- LATENCY=3 with 4 back-to-back requests 0x3000..0x300C -> 4 consecutive rsp_valid pulses starting exactly 3 cycles after the first accept, in order.
- Requests 0x2FFC, 0x4000 and 0x3002 -> each gets rsp_valid=1, rsp_err=1, rsp_instr=0. Load to 0x4000 -> ld_err=1 for one cycle and no array change.
- ld_en held high together with req_valid for 2 cycles -> req_ready=0 during both. The request is accepted the following cycle and returns the freshly loaded word.
- Assert Reset while 3 LATENCY=3 responses are in flight -> no rsp_valid in the next 3 cycles. After reset, a read of 0x3000 still returns 0x20080005.
- Load 0xDEADBEEF at 0x3FFC, then request 0x3FFC -> 0xDEADBEEF, rsp_err=0. This is the last word of the window.

Source files
------------

// File: rtl/imem_fetch_responder_pkg.sv
// Shared constants, pipeline stage type and address-decode helper for the
// instruction-memory fetch responder.
package imem_fetch_responder_pkg;

    localparam logic [31:0] IM_BASE        = 32'h00003000;
    localparam int          IM_DEPTH_LOG2  = 10;
    localparam logic [31:0] IM_NOP         = 32'h00000000;
    localparam int          IM_MAX_LATENCY = 4;

    // One slot of the response pipeline.
    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] addr;
        logic [31:0] data;
    } stage_t;

    // True when a byte address is misaligned or lies outside the program
    // window. The window limit is formed in 33 bits so a window that ends
    // exactly at the top of the address space does not wrap to zero.
    function automatic logic addr_bad(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input int unsigned depth_log2);
        logic [32:0] limit;
        limit = {1'b0, base} + (33'd4 << depth_log2);
        return (addr[1:0] != 2'b00) || (addr < base) || ({1'b0, addr} >= limit);
    endfunction

endpackage

// File: rtl/imem_fetch_responder_ram.sv
// Program store: synchronous write port for loading, combinational read
// port for fetches. Contents are deliberately never reset.
module im_ram
    import imem_fetch_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = IM_DEPTH_LOG2
) (
    input  logic                  Clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [31:0]           wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**DEPTH_LOG2];

    // Write the load word at the clock edge.
    always_ff @(posedge Clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/imem_fetch_responder.sv
// Instruction-memory fetch responder: accepts one PC per cycle, returns the
// instruction word LATENCY cycles later (legal LATENCY range 1..4), flags
// misaligned or out-of-window addresses, and accepts program loads that take
// priority over fetches.
module imem_fetch_responder
    import imem_fetch_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = IM_BASE,
    parameter int          DEPTH_LOG2 = IM_DEPTH_LOG2,
    parameter int          LATENCY    = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_instr,
    output logic [31:0] rsp_addr,
    output logic        rsp_err,
    input  logic        ld_en,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data,
    output logic        ld_err
);

    logic                  accept;
    logic                  req_err;
    logic                  ld_bad;
    logic [DEPTH_LOG2-1:0] req_index;
    logic [DEPTH_LOG2-1:0] ld_index;
    logic [31:0]           ram_rdata;
    stage_t                fresh;
    stage_t                tail;

    // A load owns the cycle, so a concurrent fetch is stalled.
    assign req_ready = !Reset && !ld_en;
    assign accept    = req_valid && req_ready;

    assign req_err = addr_bad(req_addr, BASE_ADDR, DEPTH_LOG2);
    assign ld_bad  = addr_bad(ld_addr, BASE_ADDR, DEPTH_LOG2);

    // BASE_ADDR is word aligned, so subtracting only the index bits gives
    // the same word index as a full-width subtraction for in-window addresses.
    assign req_index = req_addr[DEPTH_LOG2+1:2] - BASE_ADDR[DEPTH_LOG2+1:2];
    assign ld_index  = ld_addr[DEPTH_LOG2+1:2]  - BASE_ADDR[DEPTH_LOG2+1:2];

    im_ram #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_ram (
        .Clk   (Clk),
        .we    (ld_en && !ld_bad),
        .waddr (ld_index),
        .wdata (ld_data),
        .raddr (req_index),
        .rdata (ram_rdata)
    );

    // Entry formed at accept time; the word is captured now so later loads
    // cannot disturb a fetch already in flight.
    always_comb begin
        fresh.valid = accept;
        fresh.err   = req_err;
        fresh.addr  = req_addr;
        fresh.data  = req_err ? IM_NOP : ram_rdata;
    end

    generate
        if (LATENCY == 1) begin : g_direct
            assign tail = fresh;
        end else begin : g_pipe
            stage_t pipe [LATENCY-1];

            // Shift the intermediate stages; reset drops every in-flight fetch.
            always_ff @(posedge Clk) begin
                if (Reset) begin
                    for (int i = 0; i < LATENCY - 1; i++) begin
                        pipe[i].valid <= 1'b0;
                    end
                end else begin
                    pipe[0] <= fresh;
                    for (int i = 1; i < LATENCY - 1; i++) begin
                        pipe[i] <= pipe[i-1];
                    end
                end
            end

            assign tail = pipe[LATENCY-2];
        end
    endgenerate

    // Final stage drives the response ports and holds its payload between pulses.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rsp_valid <= 1'b0;
            rsp_instr <= IM_NOP;
            rsp_addr  <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= tail.valid;
            if (tail.valid) begin
                rsp_instr <= tail.data;
                rsp_addr  <= tail.addr;
                rsp_err   <= tail.err;
            end
        end
    end

    // Report a dropped load for one cycle; a load during reset never reports.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ld_err <= 1'b0;
        end else begin
            ld_err <= ld_en && ld_bad;
        end
    end

endmodule
